// File: rtl/dma_copy_engine.sv
// dma_copy_engine: word-granular memory-to-memory copy engine.
//
// Device side (register file, always accepted, response one cycle later):
//   device_req_i/addr_i/we_i/be_i/wdata_i -> device_rvalid_o/rdata_o
//   0x00 SRC, 0x04 DST, 0x08 LEN, 0x0C CTRL{irq_en,start}, 0x10 STATUS{err,done,busy}
// Host side (single outstanding transaction):
//   host_req_o/addr_o/we_o/be_o/wdata_o, host_gnt_i, host_rvalid_i/rdata_i/err_i
// irq_o: level interrupt, STATUS.done & CTRL.irq_en.
module dma_copy_engine #(
    parameter int LenWidth     = 16,
    parameter int RegAddrWidth = 5
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        device_req_i,
    input  logic [31:0] device_addr_i,
    input  logic        device_we_i,
    input  logic [3:0]  device_be_i,
    input  logic [31:0] device_wdata_i,
    output logic        device_rvalid_o,
    output logic [31:0] device_rdata_o,
    output logic        host_req_o,
    input  logic        host_gnt_i,
    output logic [31:0] host_addr_o,
    output logic        host_we_o,
    output logic [3:0]  host_be_o,
    output logic [31:0] host_wdata_o,
    input  logic        host_rvalid_i,
    input  logic [31:0] host_rdata_i,
    input  logic        host_err_i,
    output logic        irq_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_DONE, S_ABORT
    } state_t;

    localparam int SelW = RegAddrWidth - 2;
    localparam logic [SelW-1:0] A_SRC    = SelW'(0);
    localparam logic [SelW-1:0] A_DST    = SelW'(1);
    localparam logic [SelW-1:0] A_LEN    = SelW'(2);
    localparam logic [SelW-1:0] A_CTRL   = SelW'(3);
    localparam logic [SelW-1:0] A_STATUS = SelW'(4);

    state_t              r_state;
    logic [31:0]         r_src, r_dst, r_cur_src, r_cur_dst, r_buf;
    logic [LenWidth-1:0] r_len, r_remaining;
    logic                r_irq_en, r_done, r_err;
    logic                r_rvalid;
    logic [31:0]         r_rdata;

    logic [SelW-1:0]     w_sel;
    logic                w_wr, w_busy, w_start, w_w1c;
    logic [31:0]         w_mask, w_src_new, w_dst_new, w_len_ext, w_len_new, w_rd_mux;
    logic                w_unused;

    assign w_sel  = device_addr_i[RegAddrWidth-1:2];
    assign w_wr   = device_req_i & device_we_i;
    assign w_busy = (r_state != S_IDLE);
    assign w_mask = {{8{device_be_i[3]}}, {8{device_be_i[2]}},
                     {8{device_be_i[1]}}, {8{device_be_i[0]}}};

    // Byte-enable merge of the write data into the current register value
    assign w_src_new = (r_src & ~w_mask) | (device_wdata_i & w_mask);
    assign w_dst_new = (r_dst & ~w_mask) | (device_wdata_i & w_mask);
    assign w_len_ext = {{(32-LenWidth){1'b0}}, r_len};
    assign w_len_new = (w_len_ext & ~w_mask) | (device_wdata_i & w_mask);

    assign w_start = w_wr & (w_sel == A_CTRL) & device_be_i[0] & device_wdata_i[0] & ~w_busy;
    assign w_w1c   = w_wr & (w_sel == A_STATUS) & device_be_i[0];

    // Address bits outside the register select are don't-care
    assign w_unused = ^{device_addr_i[31:RegAddrWidth], device_addr_i[1:0]};

    always_comb begin
        w_rd_mux = 32'h0;
        case (w_sel)
            A_SRC:    w_rd_mux = r_src;
            A_DST:    w_rd_mux = r_dst;
            A_LEN:    w_rd_mux = w_len_ext;
            A_CTRL:   w_rd_mux = {30'h0, r_irq_en, 1'b0};
            A_STATUS: w_rd_mux = {29'h0, r_err, r_done, w_busy};
            default:  w_rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_src       <= '0;
            r_dst       <= '0;
            r_len       <= '0;
            r_cur_src   <= '0;
            r_cur_dst   <= '0;
            r_remaining <= '0;
            r_buf       <= '0;
            r_irq_en    <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_rvalid <= device_req_i;
            r_rdata  <= (device_req_i & ~device_we_i) ? w_rd_mux : 32'h0;

            // Transfer parameters are frozen while a copy is in flight
            if (w_wr && !w_busy) begin
                if (w_sel == A_SRC) r_src <= {w_src_new[31:2], 2'b00};
                if (w_sel == A_DST) r_dst <= {w_dst_new[31:2], 2'b00};
                if (w_sel == A_LEN) r_len <= w_len_new[LenWidth-1:0];
            end
            if (w_wr && (w_sel == A_CTRL) && device_be_i[0]) r_irq_en <= device_wdata_i[1];

            // W1C first; FSM sets below override so a same-cycle set wins
            if (w_w1c) begin
                if (device_wdata_i[1]) r_done <= 1'b0;
                if (device_wdata_i[2]) r_err  <= 1'b0;
            end

            case (r_state)
                S_IDLE: if (w_start) begin
                    r_cur_src   <= r_src;
                    r_cur_dst   <= r_dst;
                    r_remaining <= r_len;
                    r_err       <= 1'b0;
                    // Zero-length copy completes immediately with no bus traffic
                    if (r_len == '0) r_done <= 1'b1;
                    else begin
                        r_done  <= 1'b0;
                        r_state <= S_RD_REQ;
                    end
                end
                S_RD_REQ:  if (host_gnt_i) r_state <= S_RD_WAIT;
                S_RD_WAIT: if (host_rvalid_i) begin
                    if (host_err_i) r_state <= S_ABORT;
                    else begin
                        r_buf   <= host_rdata_i;
                        r_state <= S_WR_REQ;
                    end
                end
                S_WR_REQ:  if (host_gnt_i) r_state <= S_WR_WAIT;
                S_WR_WAIT: if (host_rvalid_i) begin
                    if (host_err_i) r_state <= S_ABORT;
                    else begin
                        r_cur_src   <= r_cur_src + 32'd4;
                        r_cur_dst   <= r_cur_dst + 32'd4;
                        r_remaining <= r_remaining - LenWidth'(1);
                        r_state     <= (r_remaining == LenWidth'(1)) ? S_DONE : S_RD_REQ;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                S_ABORT: begin
                    r_done  <= 1'b1;
                    r_err   <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Bus fields are decoded from registered state only, so they hold steady
    // for as long as a request waits for its grant.
    assign host_req_o      = (r_state == S_RD_REQ) | (r_state == S_WR_REQ);
    assign host_we_o       = (r_state == S_WR_REQ);
    assign host_addr_o     = (r_state == S_RD_REQ) ? r_cur_src :
                             (r_state == S_WR_REQ) ? r_cur_dst : 32'h0;
    assign host_wdata_o    = (r_state == S_WR_REQ) ? r_buf : 32'h0;
    assign host_be_o       = host_req_o ? 4'hF : 4'h0;
    assign device_rvalid_o = r_rvalid;
    assign device_rdata_o  = r_rdata;
    assign irq_o           = r_done & r_irq_en;

endmodule

// File: tb/tb_dma_copy_engine.sv
module tb_dma_copy_engine;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        device_req_i, device_we_i;
    logic [31:0] device_addr_i, device_wdata_i;
    logic [3:0]  device_be_i;
    logic        device_rvalid_o;
    logic [31:0] device_rdata_o;
    logic        host_req_o, host_gnt_i, host_we_o, host_rvalid_i, host_err_i, irq_o;
    logic [31:0] host_addr_o, host_wdata_o, host_rdata_i;
    logic [3:0]  host_be_o;

    always #5 clk = ~clk;

    dma_copy_engine dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .device_req_i(device_req_i), .device_addr_i(device_addr_i),
        .device_we_i(device_we_i), .device_be_i(device_be_i),
        .device_wdata_i(device_wdata_i), .device_rvalid_o(device_rvalid_o),
        .device_rdata_o(device_rdata_o),
        .host_req_o(host_req_o), .host_gnt_i(host_gnt_i), .host_addr_o(host_addr_o),
        .host_we_o(host_we_o), .host_be_o(host_be_o), .host_wdata_o(host_wdata_o),
        .host_rvalid_i(host_rvalid_i), .host_rdata_i(host_rdata_i),
        .host_err_i(host_err_i), .irq_o(irq_o)
    );

    int total = 0, bad = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic [31:0] mem [bit [31:0]];
    txn_t        log_q[$];
    txn_t        exp_q[$];
    logic [31:0] snap[$];
    logic [31:0] exp_status;
    logic        exp_irq;
    logic [31:0] x_dst;
    int          exp_nwr;

    bit   resp_en = 1'b1;
    int   stall = 0, err_rd = -1, rd_cnt = 0, wait_cnt = 0;
    bit   pend = 1'b0;
    txn_t pend_t, cap_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Bus target: grant after `stall` waiting cycles, respond the cycle after grant.
    initial begin
        host_gnt_i = 0; host_rvalid_i = 0; host_rdata_i = 0; host_err_i = 0;
        forever begin
            @(negedge clk);
            if (resp_en) begin
                txn_t cur;
                bit   had;
                had = pend;
                host_gnt_i = 0; host_rvalid_i = 0; host_err_i = 0; host_rdata_i = 0;
                if (had) begin
                    pend = 0;
                    host_rvalid_i = 1;
                    if (pend_t.we) mem[pend_t.addr] = pend_t.data;
                    else begin
                        if (rd_cnt == err_rd) host_err_i = 1;
                        else host_rdata_i = mem.exists(pend_t.addr) ? mem[pend_t.addr] : 32'h0;
                        rd_cnt++;
                    end
                end else if (host_req_o) begin
                    cur.we = host_we_o; cur.addr = host_addr_o; cur.data = host_wdata_o;
                    if (wait_cnt == 0) cap_t = cur;
                    else begin
                        chk("stall_addr", cur.addr, cap_t.addr);
                        chk("stall_we", {31'h0, cur.we}, {31'h0, cap_t.we});
                        chk("stall_wdata", cur.data, cap_t.data);
                    end
                    if (wait_cnt >= stall) begin
                        chk("host_be", {28'h0, host_be_o}, 32'hF);
                        host_gnt_i = 1;
                        pend = 1;
                        pend_t = cur;
                        log_q.push_back(cur);
                        wait_cnt = 0;
                    end else wait_cnt++;
                end
            end
        end
    end

    task automatic reg_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        device_req_i = 1; device_we_i = 1; device_addr_i = a; device_wdata_i = d; device_be_i = be;
        @(negedge clk);
        device_req_i = 0; device_we_i = 0;
    endtask

    task automatic reg_rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        device_req_i = 1; device_we_i = 0; device_addr_i = a;
        @(negedge clk);
        d = device_rdata_o;
        chk("rvalid", {31'h0, device_rvalid_o}, 32'h1);
        device_req_i = 0;
    endtask

    // Back-to-back STATUS reads until done with busy clear.
    task automatic poll(output int busy_n, output logic [31:0] first, output logic [31:0] last);
        logic [31:0] st;
        bit          to;
        device_req_i = 1; device_we_i = 0; device_addr_i = 32'h10;
        busy_n = 0; to = 1; first = 0; st = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            st = device_rdata_o;
            if (i == 0) first = st;
            if (st[0]) busy_n++;
            else if (st[1]) begin
                to = 0;
                break;
            end
        end
        last = st;
        device_req_i = 0;
        chk("done_timeout", {31'h0, to}, 32'h0);
    endtask

    // Reference model: word i is read from src+4i then written to dst+4i;
    // a read error at index k stops the copy before its write.
    task automatic start_xfer(input logic [31:0] src, input logic [31:0] dst, input int len,
                              input int stl, input int erd, input logic ien);
        txn_t t;
        int   k;
        log_q.delete(); exp_q.delete(); snap.delete();
        stall = stl; err_rd = erd; rd_cnt = 0; wait_cnt = 0;
        for (int i = 0; i < len; i++) begin
            logic [31:0] v;
            v = $urandom;
            snap.push_back(v);
            mem[src + 32'(4 * i)] = v;
            mem[dst + 32'(4 * i)] = ~v;
        end
        k = (erd >= 0 && erd < len) ? erd : -1;
        exp_nwr = 0;
        for (int i = 0; i < len; i++) begin
            t.we = 0; t.addr = src + 32'(4 * i); t.data = 0;
            exp_q.push_back(t);
            if (i == k) break;
            t.we = 1; t.addr = dst + 32'(4 * i); t.data = snap[i];
            exp_q.push_back(t);
            exp_nwr++;
        end
        exp_status = (k >= 0) ? 32'h6 : 32'h2;
        exp_irq = ien;
        x_dst = dst;
        reg_wr(32'h00, src, 4'hF);
        reg_wr(32'h04, dst, 4'hF);
        reg_wr(32'h08, len, 4'hF);
        reg_wr(32'h0C, {30'h0, ien, 1'b1}, 4'hF);
    endtask

    task automatic finish_xfer(output int busy_n, output logic [31:0] first);
        logic [31:0] last;
        int n;
        poll(busy_n, first, last);
        chk("status", last, exp_status);
        chk("nlog", log_q.size(), exp_q.size());
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("txn%0d_we", i), {31'h0, log_q[i].we}, {31'h0, exp_q[i].we});
            chk($sformatf("txn%0d_addr", i), log_q[i].addr, exp_q[i].addr);
            if (exp_q[i].we) chk($sformatf("txn%0d_data", i), log_q[i].data, exp_q[i].data);
        end
        for (int i = 0; i < exp_nwr; i++)
            chk($sformatf("mem%0d", i), mem[x_dst + 32'(4 * i)], snap[i]);
        chk("irq", {31'h0, irq_o}, {31'h0, exp_irq});
    endtask

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[18];

    initial begin
        logic [31:0] rd, first;
        int busy_n, len;
        bit ok;

        vt[0]  = '{0, 32'h00, 32'h0,        4'h0, 32'h0};
        vt[1]  = '{0, 32'h04, 32'h0,        4'h0, 32'h0};
        vt[2]  = '{0, 32'h08, 32'h0,        4'h0, 32'h0};
        vt[3]  = '{0, 32'h0C, 32'h0,        4'h0, 32'h0};
        vt[4]  = '{0, 32'h10, 32'h0,        4'h0, 32'h0};
        vt[5]  = '{1, 32'h00, 32'hFFFFFFFF, 4'hF, 32'hFFFFFFFC};
        vt[6]  = '{1, 32'h00, 32'h12345678, 4'h3, 32'hFFFF5678};
        vt[7]  = '{1, 32'h04, 32'hA5A5A5A7, 4'hF, 32'hA5A5A5A4};
        vt[8]  = '{1, 32'h04, 32'h00000000, 4'h8, 32'h00A5A5A4};
        vt[9]  = '{1, 32'h08, 32'hABCD1234, 4'hF, 32'h00001234};
        vt[10] = '{1, 32'h08, 32'h0000FF00, 4'h2, 32'h0000FF34};
        vt[11] = '{1, 32'h0C, 32'h00000002, 4'hF, 32'h00000002};
        vt[12] = '{1, 32'h0C, 32'h00000000, 4'hE, 32'h00000002};
        vt[13] = '{1, 32'h0C, 32'h00000000, 4'h1, 32'h00000000};
        vt[14] = '{1, 32'h10, 32'hFFFFFFFF, 4'hF, 32'h00000000};
        vt[15] = '{1, 32'h14, 32'hFFFFFFFF, 4'hF, 32'h00000000};
        vt[16] = '{0, 32'h18, 32'h0,        4'h0, 32'h0};
        vt[17] = '{0, 32'h1C, 32'h0,        4'h0, 32'h0};

        rst_ni = 0; device_req_i = 0; device_we_i = 0; device_addr_i = 0;
        device_wdata_i = 0; device_be_i = 0;
        repeat (3) @(negedge clk);
        chk("rst_host_req", {31'h0, host_req_o}, 32'h0);
        chk("rst_host_addr", host_addr_o, 32'h0);
        chk("rst_rvalid", {31'h0, device_rvalid_o}, 32'h0);
        chk("rst_irq", {31'h0, irq_o}, 32'h0);
        rst_ni = 1;

        foreach (vt[i]) begin
            if (vt[i].we) reg_wr(vt[i].addr, vt[i].wdata, vt[i].be);
            reg_rd(vt[i].addr, rd);
            chk($sformatf("vec%0d", i), rd, vt[i].exp);
        end

        // Single word, best-case bus
        start_xfer(32'h00100000, 32'h00100100, 1, 0, -1, 1'b1);
        mem[32'h00100000] = 32'hDEADBEEF; snap[0] = 32'hDEADBEEF; exp_q[1].data = 32'hDEADBEEF;
        finish_xfer(busy_n, first);
        chk("single_busy_cycles", busy_n, 5);
        chk("single_wdata", mem[32'h00100100], 32'hDEADBEEF);

        // Four words, three stall cycles on every request
        start_xfer(32'h00100000, 32'h00101000, 4, 3, -1, 1'b1);
        finish_xfer(busy_n, first);

        // Zero length: done right away, never busy, no traffic
        start_xfer(32'h00100000, 32'h00102000, 0, 0, -1, 1'b1);
        finish_xfer(busy_n, first);
        chk("len0_first_status", first, 32'h2);
        chk("len0_busy", busy_n, 0);

        // Error on second read
        start_xfer(32'h00100000, 32'h00103000, 3, 0, 1, 1'b1);
        finish_xfer(busy_n, first);
        reg_wr(32'h10, 32'h6, 4'hF);
        reg_rd(32'h10, rd);
        chk("err_w1c_status", rd, 32'h0);
        chk("err_w1c_irq", {31'h0, irq_o}, 32'h0);

        // Parameter writes and a second start while busy are ignored
        start_xfer(32'h00104000, 32'h00105000, 2, 4, -1, 1'b0);
        reg_wr(32'h00, 32'h12345678, 4'hF);
        reg_wr(32'h0C, 32'h1, 4'hF);
        reg_rd(32'h00, rd);
        chk("busy_src_hold", rd, 32'h00104000);
        finish_xfer(busy_n, first);

        // Randomized transfers, including an address wrap and random read errors
        for (int it = 0; it < 10; it++) begin
            logic [31:0] s;
            int er;
            len = $urandom_range(1, 6);
            s = (it == 0) ? 32'hFFFFFFF8 : 32'h00200000 + 32'(it << 12);
            er = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
            start_xfer(s, 32'h00800000 + 32'(it << 12), (it == 0) ? 3 : len,
                       $urandom_range(0, 3), er, 1'($urandom_range(0, 1)));
            finish_xfer(busy_n, first);
        end

        // Async reset while a write request is pending
        resp_en = 0; host_gnt_i = 0; host_rvalid_i = 0; host_err_i = 0;
        reg_wr(32'h00, 32'h00106000, 4'hF);
        reg_wr(32'h04, 32'h00107000, 4'hF);
        reg_wr(32'h08, 32'h1, 4'hF);
        reg_wr(32'h0C, 32'h1, 4'hF);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (host_req_o && !host_we_o) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("rst_seq_rdreq", {31'h0, ok}, 32'h1);
        host_gnt_i = 1;
        @(negedge clk);
        host_gnt_i = 0; host_rvalid_i = 1; host_rdata_i = 32'h55AA55AA;
        @(negedge clk);
        host_rvalid_i = 0;
        chk("rst_seq_wrreq", {30'h0, host_req_o, host_we_o}, 32'h3);
        #1 rst_ni = 0;
        #1 chk("rst_drop_req", {31'h0, host_req_o}, 32'h0);
        @(negedge clk);
        rst_ni = 1;
        @(negedge clk);
        host_rvalid_i = 1;
        @(negedge clk);
        host_rvalid_i = 0;
        chk("rst_late_req", {31'h0, host_req_o}, 32'h0);
        reg_rd(32'h10, rd);
        chk("rst_status", rd, 32'h0);
        reg_rd(32'h00, rd);
        chk("rst_src", rd, 32'h0);
        chk("rst_idle_req", {31'h0, host_req_o}, 32'h0);
        pend = 0;
        resp_en = 1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma_copy_engine.md
Name: dma_copy_engine

Overview:
Word-granular memory-to-memory copy engine for the demo system. It sits on the system bus in two roles. As a device, it exposes a small register file to the core. As a bus host, it initiates reads and writes on the shared bus. Each word is read from a source address and written to a destination address, with a completion interrupt routed to a fast IRQ line.

Parameters:
LenWidth, 16, width of the word-count register; maximum transfer is 2^LenWidth-1 words.
RegAddrWidth, 5, device address bits decoded for register select (offsets 0x00-0x10).

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
device_req_i  in  1  register access request (always accepted)
device_addr_i  in  32  register byte address; bits [4:2] select the register
device_we_i  in  1  register write enable
device_be_i  in  4  register byte enables
device_wdata_i  in  32  register write data
device_rvalid_o  out  1  register response valid, one cycle after device_req_i
device_rdata_o  out  32  register read data
host_req_o  out  1  bus request
host_gnt_i  in  1  bus grant
host_addr_o  out  32  bus address, word-aligned
host_we_o  out  1  bus write enable
host_be_o  out  4  bus byte enables, always 4'hF
host_wdata_o  out  32  bus write data
host_rvalid_i  in  1  bus response valid
host_rdata_i  in  32  bus read data
host_err_i  in  1  bus error, qualified by host_rvalid_i
irq_o  out  1  level interrupt: STATUS.done & CTRL.irq_en

Behaviour:
- Reset values: all outputs 0. All registers 0. State IDLE.
- Register map (byte offsets):
  - 0x00 SRC (RW). Bits [1:0] read as 0.
  - 0x04 DST (RW). Bits [1:0] read as 0.
  - 0x08 LEN (RW, LenWidth bits, zero-extended on read).
  - 0x0C CTRL: bit0 start (write-1 pulse, reads 0); bit1 irq_en (RW).
  - 0x10 STATUS (RO except W1C bits): bit0 busy; bit1 done (W1C); bit2 err (W1C).
  - Other offsets read 0; writes to them are ignored.
- Register writes honour device_be_i per byte. Start is taken from byte 0 only.
- device_rvalid_o is device_req_i registered, one cycle later. device_rdata_o is registered in the same cycle.
- While busy:
  - Writes to SRC, DST, LEN and to the start bit are ignored.
  - irq_en and the W1C bits remain writable.
- Start: a write of start=1 while IDLE does the following in that cycle:
  - latches cur_src/cur_dst from SRC/DST and remaining from LEN;
  - clears done and err.
  - If LEN==0, done is set the next cycle, busy never asserts and there is no bus traffic. Otherwise the FSM goes to RD_REQ.
- FSM:
  - IDLE
  - RD_REQ: host_req_o=1, we=0, addr=cur_src. Stays until host_gnt_i, then → RD_WAIT.
  - RD_WAIT: host_req_o=0. On host_rvalid_i:
    - if err → ABORT;
    - otherwise latch rdata into the data buffer and → WR_REQ.
  - WR_REQ: host_req_o=1, we=1, addr=cur_dst, wdata=buffer. On host_gnt_i → WR_WAIT.
  - WR_WAIT: on host_rvalid_i:
    - if err → ABORT;
    - otherwise cur_src+=4, cur_dst+=4, remaining-=1. If remaining was 1 → DONE; else → RD_REQ.
  - DONE: set done, → IDLE (one cycle).
  - ABORT: set err and done, → IDLE (one cycle).
- host_addr_o, host_we_o and host_wdata_o stay stable while host_req_o=1 and gnt is not yet seen.
- Only one outstanding bus transaction at a time. A grant with no request is ignored. An rvalid outside the WAIT states is ignored.
- busy = (state != IDLE).
- Address arithmetic is modulo 2^32 and wraps silently (0xFFFFFFFC+4 = 0x0).
- Simultaneous events:
  - A W1C of done in the same cycle the FSM sets done: the set wins.
  - A start write and a STATUS write in the same cycle cannot occur (single register port).
- Async reset mid-transfer: host_req_o drops immediately, the FSM returns to IDLE and all registers clear. Late host_rvalid_i after reset release is ignored.
- Throughput: at best 4 cycles per word (gnt same cycle as req, rvalid next cycle).

Test Plan:
- Single word: SRC=0x00100000, DST=0x00100100, LEN=1, start; memory[0x100000]=0xDEADBEEF.
  - Expect one read, then one write of 0xDEADBEEF to 0x00100100.
  - Expect busy for 5 cycles, done=1, irq_o=1 with irq_en=1.
- Four words with the gnt held low 3 cycles per request: SRC=0x00100000, DST=0x00101000, LEN=4.
  - Expect read addresses 0x100000..0x10000C interleaved with write addresses 0x101000..0x10100C.
  - Expect request fields stable during stalls and the final memory contents equal to the source.
- LEN=0 start: no host_req_o ever; done=1 one cycle after the CTRL write; busy never 1.
- Error on the second read (host_err_i=1 with rvalid), LEN=3:
  - Exactly one write occurs; STATUS reads 0x6 (err|done).
  - A W1C write of 0x6 to STATUS clears it to 0 and irq_o drops.
- Write SRC=0x12345678 and issue a start while busy: SRC readback is unchanged and the transfer completes with its original parameters.
- Assert rst_ni low while in WR_REQ:
  - host_req_o is 0 in the same cycle.
  - After release, STATUS=0, SRC=0, and a late host_rvalid_i causes no state change.
